approx_mul_pipe: RTL

- Parametrised, pipelined successor to the fixed 8x8 quadrant-decomposed approximate multiplier.
- Splits each N-bit operand into high and low halves, forms four half-width partial products (HH, HL, LH, LL) and recombines them under a per-transaction accuracy mode.
- Adds valid/ready flow control, a 3-stage pipeline with backpressure, and a saturating completed-operation counter.
- Sits between operand producers and accumulate/consume logic in the approximate-arithmetic datapath.

---
 rtl/approx_mul_pipe.sv | 113 +++++++++++
 1 files changed

// File: rtl/approx_mul_pipe.sv
// Pipelined approximate N x N unsigned multiplier built from four half-width partial
// products, with a per-transaction accuracy mode and a saturating completion counter.
module approx_mul_pipe #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_prod,
  output logic [CNT_W-1:0] op_count
);
  localparam int H = N / 2;

  localparam logic [1:0] MODE_DROP_LL = 2'd1;
  localparam logic [1:0] MODE_HH_ONLY = 2'd2;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Once out_valid is high, out_prod holds until out_ready is seen. in_ready depends
  // combinationally on out_ready, because the whole pipe advances as one unit.
  logic en;
  logic v1, v2, v3;

  logic [N-1:0]   a1, b1;
  logic [1:0]     m1, m2;
  logic [N-1:0]   hh2, hl2, lh2, ll2;
  logic [2*N-1:0] p3;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign out_prod  = p3;

  // Stage 1 -> 2: exact half-width partial products, zero-extended to full width.
  logic [H-1:0] ah, al, bh, bl;
  logic [N-1:0] hh_c, hl_c, lh_c, ll_c;

  assign ah   = a1[N-1:H];
  assign al   = a1[H-1:0];
  assign bh   = b1[N-1:H];
  assign bl   = b1[H-1:0];
  assign hh_c = {{(N-H){1'b0}}, ah} * {{(N-H){1'b0}}, bh};
  assign hl_c = {{(N-H){1'b0}}, ah} * {{(N-H){1'b0}}, bl};
  assign lh_c = {{(N-H){1'b0}}, al} * {{(N-H){1'b0}}, bh};
  assign ll_c = {{(N-H){1'b0}}, al} * {{(N-H){1'b0}}, bl};

  // Stage 2 -> 3: recombination at 2N+1 bits; the carry bit is provably zero.
  logic [N:0]   mid;
  logic [2*N:0] hh_w, mid_w, ll_w, sum;

  always_comb begin
    mid   = {1'b0, hl2} + {1'b0, lh2};
    hh_w  = {1'b0, hh2, {N{1'b0}}};
    mid_w = {{(N-H){1'b0}}, mid, {H{1'b0}}};
    ll_w  = {{(N+1){1'b0}}, ll2};
    sum   = hh_w + mid_w + ll_w;
    case (m2)
      MODE_DROP_LL: sum = hh_w + mid_w;
      MODE_HH_ONLY: sum = hh_w;
      default:      sum = hh_w + mid_w + ll_w;
    endcase
    assert (!sum[2*N]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      m1  <= '0;
      m2  <= '0;
      hh2 <= '0;
      hl2 <= '0;
      lh2 <= '0;
      ll2 <= '0;
      p3  <= '0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        a1 <= in_a;
        b1 <= in_b;
        m1 <= in_mode;
      end
      if (v1) begin
        hh2 <= hh_c;
        hl2 <= hl_c;
        lh2 <= lh_c;
        ll2 <= ll_c;
        m2  <= m1;
      end
      if (v2) p3 <= sum[2*N-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (v3 && out_ready && (op_count != '1)) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule
